// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt/exception controller for a simple in-order
// pipeline. Synchronises raw request lines, latches edges, arbitrates against
// a mask, and sequences ENTER/SERVICE/RETURN with one-cycle redirect strobes.
module irq_ctrl #(
    parameter int unsigned        NUM_IRQ  = 4,
    parameter logic [NUM_IRQ-1:0] EDGE     = {NUM_IRQ{1'b1}},
    parameter logic [31:0]        VEC_BASE = 32'h0000_0100,
    parameter int unsigned        ID_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               excp,
    input  logic               iret,
    input  logic               jmp,
    input  logic [31:0]        pc_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [31:0]        pc_out,
    output logic               pc_en,
    output logic               flush,
    output logic [31:0]        epc,
    output logic [ID_W-1:0]    cause,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic               double_fault
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_SERVICE,
        ST_RETURN
    } state_t;

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend_vec;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] sel_onehot;
    logic [NUM_IRQ-1:0] take_clr;
    logic [ID_W-1:0]    sel_id;
    logic               any_elig;

    logic [31:0]        epc_q, epc_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic [ID_W-1:0]    cause_q, cause_d;
    logic               dfault_q, dfault_d;

    // Vector table slot for a cause: 8 bytes per entry.
    function automatic logic [31:0] vec_addr(input logic [ID_W-1:0] id);
        return VEC_BASE + (32'(id) << 3);
    endfunction

    // Two-flop synchroniser plus one delayed copy for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge lines latch on a synchronised rise; level lines follow sync_irq directly.
    always_comb begin
        rise     = sync2_q & ~prev_q;
        pend_vec = (EDGE & edge_pend_q) | (~EDGE & sync2_q);
        eligible = pend_vec & mask_q;
    end

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        any_elig   = 1'b0;
        sel_id     = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !any_elig) begin
                any_elig      = 1'b1;
                sel_id        = ID_W'(i);
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Pending-set has priority over the take-clear in the same cycle; mask writes land in any state.
    always_comb begin
        edge_pend_d = ((edge_pend_q & ~take_clr) | rise) & EDGE;
        mask_d      = mask_we ? mask_wdata : mask_q;
    end

    // Next-state decode and the registered context (epc, cause, redirect target, double fault).
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        pc_out_d = pc_out_q;
        dfault_d = dfault_q;
        take_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (excp) begin
                    state_d  = ST_ENTER;
                    cause_d  = ID_W'(NUM_IRQ);
                    epc_d    = pc_in;
                    pc_out_d = vec_addr(ID_W'(NUM_IRQ));
                end else if (any_elig && !jmp) begin
                    state_d  = ST_ENTER;
                    cause_d  = sel_id;
                    epc_d    = pc_in;
                    pc_out_d = vec_addr(sel_id);
                    take_clr = sel_onehot;
                end
            end
            ST_ENTER: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (iret) begin
                    state_d  = ST_RETURN;
                    pc_out_d = epc_q;
                end else if (excp) begin
                    dfault_d = 1'b1;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and context registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            edge_pend_q <= '0;
            mask_q      <= '0;
            epc_q       <= '0;
            cause_q     <= '0;
            pc_out_q    <= '0;
            dfault_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_pend_q <= edge_pend_d;
            mask_q      <= mask_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            pc_out_q    <= pc_out_d;
            dfault_q    <= dfault_d;
        end
    end

    // Strobes are decoded from state alone so an asynchronous reset kills them at once.
    always_comb begin
        pc_en        = (state_q == ST_ENTER) || (state_q == ST_RETURN);
        flush        = (state_q == ST_ENTER) || (state_q == ST_RETURN);
        in_service   = (state_q == ST_SERVICE);
        pc_out       = pc_out_q;
        epc          = epc_q;
        cause        = cause_q;
        pending      = pend_vec;
        double_fault = dfault_q;
    end

endmodule
